// File: rtl/exception_controller_pkg.sv
// Shared definitions for the exception controller: cause codes, FSM encoding,
// special-register indices and flush-timer width.
package exception_controller_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE      = 3'd0,
    CAUSE_PANIC     = 3'd1,
    CAUSE_ILLEGAL   = 3'd2,
    CAUSE_ITLB_MISS = 3'd3,
    CAUSE_DTLB_MISS = 3'd4,
    CAUSE_PRIV      = 3'd5,
    CAUSE_DOUBLE    = 3'd6
  } exc_cause_e;

  localparam int unsigned STATE_W = 2;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_FLUSH    = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;

  localparam logic [1:0] RM_IDX_EPC   = 2'd0;
  localparam logic [1:0] RM_IDX_EADDR = 2'd1;
  localparam logic [1:0] RM_IDX_CAUSE = 2'd2;
  localparam logic [1:0] RM_IDX_COUNT = 2'd3;

  localparam int unsigned TIMER_W = 4;

endpackage

// File: rtl/exc_flush_timer.sv
// Loadable down-counter; done_o is high for the single cycle in which a loaded
// count has reached zero.
module exc_flush_timer
  import exception_controller_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  output logic               done_o
);

  logic [TIMER_W-1:0] count_q, count_d;
  logic               active_q, active_d;
  logic               done_q, done_d;

  always_comb begin
    count_d  = count_q;
    active_d = active_q;
    if (load_i) begin
      count_d  = load_val_i;
      active_d = 1'b1;
    end else if (active_q) begin
      if (count_q != '0) count_d = count_q - TIMER_W'(1);
      else               active_d = 1'b0;
    end
    done_d = active_d && (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/exception_controller.sv
// Privileged control-flow sequencer: exceptions, iret and tlbwrite at commit.
// Optional accepted-exception counter at rm_idx=3 when EXC_COUNTER_EN is defined.
module exception_controller
  import exception_controller_pkg::*;
#(
  parameter int unsigned      XLEN            = 32,
  parameter logic [XLEN-1:0]  EXC_VECTOR      = XLEN'(32'h0000_2000),
  parameter int unsigned      FLUSH_CYCLES    = 2,
  parameter bit               BOOT_SUPERVISOR = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exc_valid,
  input  logic [2:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_addr,
  input  logic            iret_commit,
  input  logic            tlbwrite_commit,
  input  logic [XLEN-1:0] tlb_va,
  input  logic [XLEN-1:0] tlb_pa,
  input  logic [1:0]      rm_idx,
  output logic [XLEN-1:0] rm_rdata,
  output logic            supervisor,
  output logic            flush,
  output logic            busy,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            tlb_we,
  output logic [XLEN-1:0] tlb_we_va,
  output logic [XLEN-1:0] tlb_we_pa
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [XLEN-1:0]    rm0_q, rm0_d, rm1_q, rm1_d, rm2_q, rm2_d;
  logic               supervisor_q, supervisor_d;
  logic               flush_q, flush_d, busy_q, busy_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;
  logic               tlb_we_q, tlb_we_d;
  logic [XLEN-1:0]    tlb_va_q, tlb_va_d, tlb_pa_q, tlb_pa_d;
  logic               is_iret_q, is_iret_d;
  logic               timer_load, timer_done, take_exc;
  logic [2:0]         cause_c;
  logic [XLEN-1:0]    cnt_rd;

  exc_flush_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (timer_load),
    .load_val_i (TIMER_W'(FLUSH_CYCLES - 1)),
    .done_o     (timer_done)
  );

  always_comb begin
    state_d          = state_q;
    rm0_d            = rm0_q;
    rm1_d            = rm1_q;
    rm2_d            = rm2_q;
    supervisor_d     = supervisor_q;
    flush_d          = 1'b0;
    busy_d           = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    tlb_we_d         = 1'b0;
    tlb_va_d         = tlb_va_q;
    tlb_pa_d         = tlb_pa_q;
    is_iret_d        = is_iret_q;
    timer_load       = 1'b0;
    take_exc         = 1'b0;
    cause_c          = exc_cause;

    case (state_q)
      ST_IDLE: begin
        // Privileged ops from user mode fold into the exception path as PRIV.
        if (exc_valid || ((iret_commit || tlbwrite_commit) && !supervisor_q)) begin
          take_exc = 1'b1;
          cause_c  = exc_valid ? exc_cause : CAUSE_PRIV;
          if (supervisor_q) begin
            cause_c = CAUSE_DOUBLE;
          end else begin
            rm0_d = exc_pc;
            rm1_d = exc_addr;
          end
          rm2_d         = XLEN'(cause_c);
          supervisor_d  = 1'b1;
          redirect_pc_d = EXC_VECTOR;
          is_iret_d     = 1'b0;
          state_d       = ST_FLUSH;
          flush_d       = 1'b1;
          busy_d        = 1'b1;
          timer_load    = 1'b1;
        end else if (iret_commit) begin
          is_iret_d  = 1'b1;
          state_d    = ST_FLUSH;
          flush_d    = 1'b1;
          busy_d     = 1'b1;
          timer_load = 1'b1;
        end else if (tlbwrite_commit) begin
          tlb_we_d = 1'b1;
          tlb_va_d = tlb_va;
          tlb_pa_d = tlb_pa;
        end
      end
      ST_FLUSH: begin
        flush_d = 1'b1;
        busy_d  = 1'b1;
        if (timer_done) begin
          state_d          = ST_REDIRECT;
          redirect_valid_d = 1'b1;
          if (is_iret_q) begin
            redirect_pc_d = rm0_q;
            supervisor_d  = 1'b0;
          end
        end
      end
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      rm0_q            <= '0;
      rm1_q            <= '0;
      rm2_q            <= '0;
      supervisor_q     <= BOOT_SUPERVISOR;
      flush_q          <= 1'b0;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      tlb_we_q         <= 1'b0;
      tlb_va_q         <= '0;
      tlb_pa_q         <= '0;
      is_iret_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      rm0_q            <= rm0_d;
      rm1_q            <= rm1_d;
      rm2_q            <= rm2_d;
      supervisor_q     <= supervisor_d;
      flush_q          <= flush_d;
      busy_q           <= busy_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      tlb_we_q         <= tlb_we_d;
      tlb_va_q         <= tlb_va_d;
      tlb_pa_q         <= tlb_pa_d;
      is_iret_q        <= is_iret_d;
    end
  end

`ifdef EXC_COUNTER_EN
  logic [31:0] exc_cnt_q, exc_cnt_d;

  // Saturating count of accepted exceptions (PRIV and DOUBLE included).
  always_comb begin
    exc_cnt_d = exc_cnt_q;
    if (take_exc && (exc_cnt_q != '1)) exc_cnt_d = exc_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) exc_cnt_q <= '0;
    else       exc_cnt_q <= exc_cnt_d;
  end

  assign cnt_rd = XLEN'(exc_cnt_q);
`else
  assign cnt_rd = '0;
`endif

  always_comb begin
    case (rm_idx)
      RM_IDX_EPC:   rm_rdata = rm0_q;
      RM_IDX_EADDR: rm_rdata = rm1_q;
      RM_IDX_CAUSE: rm_rdata = rm2_q;
      default:      rm_rdata = cnt_rd;
    endcase
  end

  assign supervisor     = supervisor_q;
  assign flush          = flush_q;
  assign busy           = busy_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign tlb_we         = tlb_we_q;
  assign tlb_we_va      = tlb_va_q;
  assign tlb_we_pa      = tlb_pa_q;

endmodule

// File: tb/tb_exception_controller.sv
// Directed self-checking bench for exception_controller (default parameters).
module tb_exception_controller;

`ifdef EXC_COUNTER_EN
  localparam logic [31:0] EXP_CNT3 = 32'd3;
`else
  localparam logic [31:0] EXP_CNT3 = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid;
  logic [2:0]  exc_cause;
  logic [31:0] exc_pc, exc_addr;
  logic        iret_commit, tlbwrite_commit;
  logic [31:0] tlb_va, tlb_pa;
  logic [1:0]  rm_idx;
  logic [31:0] rm_rdata;
  logic        supervisor, flush, busy, redirect_valid, tlb_we;
  logic [31:0] redirect_pc, tlb_we_va, tlb_we_pa;

  int checks   = 0;
  int failures = 0;
  int fcnt;
  bit seen;

  exception_controller dut (
    .clk             (clk),
    .reset           (reset),
    .exc_valid       (exc_valid),
    .exc_cause       (exc_cause),
    .exc_pc          (exc_pc),
    .exc_addr        (exc_addr),
    .iret_commit     (iret_commit),
    .tlbwrite_commit (tlbwrite_commit),
    .tlb_va          (tlb_va),
    .tlb_pa          (tlb_pa),
    .rm_idx          (rm_idx),
    .rm_rdata        (rm_rdata),
    .supervisor      (supervisor),
    .flush           (flush),
    .busy            (busy),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .tlb_we          (tlb_we),
    .tlb_we_va       (tlb_we_va),
    .tlb_we_pa       (tlb_we_pa)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_rm(input string tag, input logic [1:0] idx, input logic [31:0] exp);
    rm_idx = idx;
    #1;
    check(tag, rm_rdata, exp);
  endtask

  task automatic clear_events();
    exc_valid       = 1'b0;
    iret_commit     = 1'b0;
    tlbwrite_commit = 1'b0;
  endtask

  // Walk from the cycle after acceptance up to the redirect cycle, counting flush cycles.
  task automatic wait_redirect(output int flush_cnt, output bit found);
    flush_cnt = 0;
    found     = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (flush) flush_cnt++;
      if (redirect_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic raise_exc(input logic [2:0] cause, input logic [31:0] pc, input logic [31:0] addr);
    exc_valid = 1'b1;
    exc_cause = cause;
    exc_pc    = pc;
    exc_addr  = addr;
    tick();
    clear_events();
  endtask

  task automatic do_iret();
    iret_commit = 1'b1;
    tick();
    clear_events();
  endtask

  initial begin
    reset = 1'b1;
    clear_events();
    exc_cause = 3'd0; exc_pc = '0; exc_addr = '0;
    tlb_va = '0; tlb_pa = '0; rm_idx = 2'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_supervisor", {31'd0, supervisor}, 32'd1);
    check("rst_flush", {31'd0, flush}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_redir_valid", {31'd0, redirect_valid}, 32'd0);
    check("rst_tlb_we", {31'd0, tlb_we}, 32'd0);
    check("rst_redir_pc", redirect_pc, 32'h0);
    check_rm("rst_rm0", 2'd0, 32'h0);
    check_rm("rst_rm2", 2'd2, 32'h0);
    check_rm("rst_rm3", 2'd3, 32'h0);

    // Boot supervisor -> user via iret (rm0=0)
    do_iret();
    wait_redirect(fcnt, seen);
    check("boot_iret_seen", {31'd0, seen}, 32'd1);
    check("boot_iret_pc", redirect_pc, 32'h0);
    check("boot_iret_user", {31'd0, supervisor}, 32'd0);
    tick();

    // Panic in user mode
    raise_exc(3'd1, 32'h100, 32'h55);
    check("panic_busy", {31'd0, busy}, 32'd1);
    check("panic_flush", {31'd0, flush}, 32'd1);
    wait_redirect(fcnt, seen);
    check("panic_seen", {31'd0, seen}, 32'd1);
    check("panic_flush_cnt", fcnt, 32'd3);
    check("panic_redir_pc", redirect_pc, 32'h2000);
    check("panic_super", {31'd0, supervisor}, 32'd1);
    check_rm("panic_rm0", 2'd0, 32'h100);
    check_rm("panic_rm1", 2'd1, 32'h55);
    check_rm("panic_rm2", 2'd2, 32'h1);
    tick();
    check("panic_idle_flush", {31'd0, flush}, 32'd0);
    check("panic_idle_busy", {31'd0, busy}, 32'd0);
    check("panic_idle_rv", {31'd0, redirect_valid}, 32'd0);

    // iret in supervisor returns to rm0
    do_iret();
    check("iret_super_during_flush", {31'd0, supervisor}, 32'd1);
    wait_redirect(fcnt, seen);
    check("iret_seen", {31'd0, seen}, 32'd1);
    check("iret_flush_cnt", fcnt, 32'd3);
    check("iret_redir_pc", redirect_pc, 32'h100);
    check("iret_user", {31'd0, supervisor}, 32'd0);
    tick();

    // tlbwrite in user mode -> PRIV exception
    tlbwrite_commit = 1'b1;
    tlb_va = 32'h1234; tlb_pa = 32'h5678;
    exc_pc = 32'h300; exc_addr = 32'h0;
    tick();
    clear_events();
    check("priv_no_tlb_we", {31'd0, tlb_we}, 32'd0);
    check("priv_busy", {31'd0, busy}, 32'd1);
    wait_redirect(fcnt, seen);
    check("priv_seen", {31'd0, seen}, 32'd1);
    check("priv_redir_pc", redirect_pc, 32'h2000);
    check_rm("priv_rm2", 2'd2, 32'h5);
    check_rm("priv_rm0", 2'd0, 32'h300);
    check_rm("priv_rm1", 2'd1, 32'h0);
    tick();

    // Back-to-back tlbwrite in supervisor
    tlbwrite_commit = 1'b1;
    tlb_va = 32'h4000; tlb_pa = 32'h8000;
    tick();
    check("tlb1_we", {31'd0, tlb_we}, 32'd1);
    check("tlb1_va", tlb_we_va, 32'h4000);
    check("tlb1_pa", tlb_we_pa, 32'h8000);
    check("tlb1_flush", {31'd0, flush}, 32'd0);
    check("tlb1_busy", {31'd0, busy}, 32'd0);
    tlb_va = 32'h4001; tlb_pa = 32'h8001;
    tick();
    clear_events();
    check("tlb2_we", {31'd0, tlb_we}, 32'd1);
    check("tlb2_va", tlb_we_va, 32'h4001);
    check("tlb2_pa", tlb_we_pa, 32'h8001);
    check("tlb2_flush", {31'd0, flush}, 32'd0);
    tick();
    check("tlb_done_we", {31'd0, tlb_we}, 32'd0);

    // Return to user (rm0=0x300), then simultaneous exc_valid + iret
    do_iret();
    wait_redirect(fcnt, seen);
    check("iret2_redir_pc", redirect_pc, 32'h300);
    tick();
    iret_commit = 1'b1;
    raise_exc(3'd2, 32'h400, 32'h44);
    wait_redirect(fcnt, seen);
    check("simul_seen", {31'd0, seen}, 32'd1);
    check("simul_redir_pc", redirect_pc, 32'h2000);
    check("simul_super", {31'd0, supervisor}, 32'd1);
    check_rm("simul_rm0", 2'd0, 32'h400);
    check_rm("simul_rm2", 2'd2, 32'h2);
    tick();

    // Nested panic in supervisor -> DOUBLE, rm0/rm1 kept
    raise_exc(3'd1, 32'h500, 32'h66);
    wait_redirect(fcnt, seen);
    check("double_redir_pc", redirect_pc, 32'h2000);
    check_rm("double_rm2", 2'd2, 32'h6);
    check_rm("double_rm0", 2'd0, 32'h400);
    check_rm("double_rm1", 2'd1, 32'h44);
    tick();

    // Reset asserted during FLUSH aborts the sequence
    raise_exc(3'd1, 32'h600, 32'h0);
    check("abort_in_flush", {31'd0, flush}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_flush", {31'd0, flush}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rv", {31'd0, redirect_valid}, 32'd0);
    check("abort_redir_pc", redirect_pc, 32'h0);
    check("abort_super", {31'd0, supervisor}, 32'd1);
    check_rm("abort_rm0", 2'd0, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (redirect_valid) seen = 1'b1;
      tick();
    end
    check("abort_no_redirect", {31'd0, seen}, 32'd0);

    // Three accepted exceptions, then an iret that must not count
    for (int i = 0; i < 3; i++) begin
      raise_exc(3'd1, 32'h700, 32'h0);
      wait_redirect(fcnt, seen);
      tick();
    end
    check_rm("cnt_after3", 2'd3, EXP_CNT3);
    do_iret();
    wait_redirect(fcnt, seen);
    tick();
    check_rm("cnt_after_iret", 2'd3, EXP_CNT3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
